// File: rtl/div_pkg.sv
// Shared widths and the response record for the divider issue/collect sequencer.
package div_pkg;

   localparam int Z_WIDTH    = 16;
   localparam int D_WIDTH    = Z_WIDTH / 2;
   localparam int PIPE_DEPTH = D_WIDTH + 3;
   localparam int TAG_WIDTH  = 4;

   // One captured divider result plus the tag it was issued with.
   typedef struct packed {
      logic [D_WIDTH:0]   q;
      logic [D_WIDTH:0]   s;
      logic               div0;
      logic               ovf;
      logic [TAG_WIDTH-1:0] tag;
   } div_rsp_t;

   localparam int RSP_W = $bits(div_rsp_t);

endpackage

// File: rtl/div_rsp_fifo.sv
// Small synchronous FIFO of divider responses. Push and pop may coincide at any
// occupancy, including full, because the slot being read is freed in the same edge.
module div_rsp_fifo
   import div_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [RSP_W-1:0] wdata_i,
   input  logic             pop_i,
   output logic [RSP_W-1:0] rdata_o,
   output logic             valid_o,
   output logic [CW-1:0]    count_o
);

   localparam int PW = $clog2(DEPTH);

   div_rsp_t          mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   assign rdata_o = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

   // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   // Storage and pointers; contents cleared on reset so the head reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= div_rsp_t'(wdata_i);
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/divider_seq.sv
// Issue/collect sequencer for the fixed-latency signed divider. Requests are
// accepted only while a response FIFO slot is reserved for them (inflight plus
// FIFO occupancy below FIFO_DEPTH), so a captured result never finds the FIFO full.
module divider_seq
   import div_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
)
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [Z_WIDTH-1:0]                req_z,
   input  logic [D_WIDTH-1:0]                req_d,
   input  logic [TAG_WIDTH-1:0]              req_tag,
   output logic                              div_ena,
   output logic [Z_WIDTH-1:0]                div_z,
   output logic [D_WIDTH-1:0]                div_d,
   input  logic [D_WIDTH:0]                  div_q,
   input  logic [D_WIDTH:0]                  div_s,
   input  logic                              div_div0,
   input  logic                              div_ovf,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [D_WIDTH:0]                  rsp_q,
   output logic [D_WIDTH:0]                  rsp_s,
   output logic                              rsp_div0,
   output logic                              rsp_ovf,
   output logic [TAG_WIDTH-1:0]              rsp_tag,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   inflight
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic                                ena_q;
   logic [Z_WIDTH-1:0]                  div_z_q, div_z_d;
   logic [D_WIDTH-1:0]                  div_d_q, div_d_d;
   logic [PIPE_DEPTH:0]                 vld_pipe_q;
   logic [PIPE_DEPTH:0][TAG_WIDTH-1:0]  tag_pipe_q;
   logic [CW-1:0]                       inflight_q, inflight_d;
   logic [CW-1:0]                       fifo_cnt;
   logic [CW:0]                         credits_used;
   logic                                accept, capture;
   div_rsp_t                            cap_rsp, head_rsp;
   logic [RSP_W-1:0]                    head_bits;

   // Credits come from registered state only; a same-cycle pop is not credited.
   assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
   assign req_ready    = ena_q && (credits_used < (CW+1)'(FIFO_DEPTH));
   assign accept       = req_valid && req_ready;
   // The last tracking stage lines up with the cycle the divider presents that result.
   assign capture      = vld_pipe_q[PIPE_DEPTH];

   assign div_ena  = ena_q;
   assign div_z    = div_z_q;
   assign div_d    = div_d_q;
   assign inflight = inflight_q;

   // Next-state for divider operands and the in-flight counter.
   always_comb begin
      div_z_d    = div_z_q;
      div_d_d    = div_d_q;
      inflight_d = inflight_q;
      if (accept) begin
         div_z_d = req_z;
         div_d_d = req_d;
      end
      case ({accept, capture})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Enable, operand registers, tracking pipe and counter; reset drops every tag
   // so stale results still inside the divider are never captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ena_q      <= 1'b0;
         div_z_q    <= '0;
         div_d_q    <= '0;
         vld_pipe_q <= '0;
         tag_pipe_q <= '0;
         inflight_q <= '0;
      end else begin
         ena_q      <= 1'b1;
         div_z_q    <= div_z_d;
         div_d_q    <= div_d_d;
         vld_pipe_q <= {vld_pipe_q[PIPE_DEPTH-1:0], accept};
         tag_pipe_q <= {tag_pipe_q[PIPE_DEPTH-1:0], req_tag};
         inflight_q <= inflight_d;
      end
   end

   // Assemble the captured record; flags pass through untouched.
   always_comb begin
      cap_rsp      = '0;
      cap_rsp.q    = div_q;
      cap_rsp.s    = div_s;
      cap_rsp.div0 = div_div0;
      cap_rsp.ovf  = div_ovf;
      cap_rsp.tag  = tag_pipe_q[PIPE_DEPTH];
   end

   div_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (capture),
      .wdata_i (cap_rsp),
      .pop_i   (rsp_ready),
      .rdata_o (head_bits),
      .valid_o (rsp_valid),
      .count_o (fifo_cnt)
   );

   assign head_rsp = div_rsp_t'(head_bits);
   assign rsp_q    = head_rsp.q;
   assign rsp_s    = head_rsp.s;
   assign rsp_div0 = head_rsp.div0;
   assign rsp_ovf  = head_rsp.ovf;
   assign rsp_tag  = head_rsp.tag;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: behavioural divider pipe, scoreboard queue filled on
// issue and drained by an independent response monitor.
module tb_divider_seq;
   import div_pkg::*;

   localparam int FD = 4;
   localparam int CW = $clog2(FD + 1);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid, req_ready;
   logic [Z_WIDTH-1:0]   req_z;
   logic [D_WIDTH-1:0]   req_d;
   logic [TAG_WIDTH-1:0] req_tag;
   logic                 div_ena;
   logic [Z_WIDTH-1:0]   div_z;
   logic [D_WIDTH-1:0]   div_d;
   logic [D_WIDTH:0]     div_q, div_s;
   logic                 div_div0, div_ovf;
   logic                 rsp_valid, rsp_ready;
   logic [D_WIDTH:0]     rsp_q, rsp_s;
   logic                 rsp_div0, rsp_ovf;
   logic [TAG_WIDTH-1:0] rsp_tag;
   logic [CW-1:0]        inflight;

   divider_seq #(.FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_z(req_z), .req_d(req_d), .req_tag(req_tag),
      .div_ena(div_ena), .div_z(div_z), .div_d(div_d),
      .div_q(div_q), .div_s(div_s), .div_div0(div_div0), .div_ovf(div_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_q(rsp_q), .rsp_s(rsp_s), .rsp_div0(rsp_div0), .rsp_ovf(rsp_ovf),
      .rsp_tag(rsp_tag), .inflight(inflight)
   );

   always #5 clk = ~clk;

   int       n_chk = 0, n_pass = 0;
   int       cyc = 0, acc_cyc = 0;
   int       out_cnt = 0, led_bad = 0, stab_bad = 0;
   bit       rnd_on = 1'b0;
   div_rsp_t sb [$];
   div_rsp_t dm [PIPE_DEPTH];
   div_rsp_t mon_cur, st_prev, mon_exp;
   bit       st_arm = 1'b0;

   // Reference signed divide: truncating quotient, remainder takes dividend sign.
   function automatic div_rsp_t ref_div(input logic [Z_WIDTH-1:0] z,
                                        input logic [D_WIDTH-1:0] d,
                                        input logic [TAG_WIDTH-1:0] tag);
      div_rsp_t r;
      int zi, di, qi, si;
      r = '0;
      r.tag = tag;
      zi = int'($signed(z));
      di = int'($signed(d));
      if (di == 0) begin
         r.div0 = 1'b1;
         r.q    = '1;
      end else begin
         qi = zi / di;
         si = zi % di;
         r.ovf = (qi > (1 << D_WIDTH) - 1) || (qi < -(1 << D_WIDTH));
         r.q = qi[D_WIDTH:0];
         r.s = si[D_WIDTH:0];
      end
      return r;
   endfunction

   function automatic div_rsp_t mk(input logic [D_WIDTH:0] q, input logic [D_WIDTH:0] s,
                                   input logic dz, input logic ov, input logic [TAG_WIDTH-1:0] t);
      div_rsp_t r;
      r.q = q; r.s = s; r.div0 = dz; r.ovf = ov; r.tag = t;
      return r;
   endfunction

   function automatic logic [63:0] outs();
      return 64'({req_ready, div_ena, div_z, div_d, rsp_valid, rsp_q, rsp_s,
                  rsp_div0, rsp_ovf, rsp_tag, inflight});
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Present a request, wait (bounded) for acceptance, then record its expected result.
   task automatic issue(input logic [Z_WIDTH-1:0] z, input logic [D_WIDTH-1:0] d,
                        input logic [TAG_WIDTH-1:0] tag, input div_rsp_t exp);
      int w = 0;
      bit ok = 1'b0;
      req_z = z; req_d = d; req_tag = tag; req_valid = 1'b1;
      while (!ok && w < 200) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1; else w++;
      end
      if (ok) begin
         sb.push_back(exp);
         acc_cyc = cyc + 1;
      end else begin
         n_chk++;
         $display("FAIL issue_timeout tag=%0d got=not_accepted exp=accepted", tag);
      end
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound, input string nm);
      int k = 0;
      while (sb.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(sb.size() == 0, nm, sb.size(), 0);
      step();
   endtask

   // Behavioural divider: result of operands sampled at edge n+1 appears PIPE_DEPTH cycles after accept.
   initial forever begin
      @(posedge clk);
      dm[0] <= ref_div(div_z, div_d, '0);
      for (int i = 1; i < PIPE_DEPTH; i++) dm[i] <= dm[i-1];
   end
   assign div_q    = dm[PIPE_DEPTH-1].q;
   assign div_s    = dm[PIPE_DEPTH-1].s;
   assign div_div0 = dm[PIPE_DEPTH-1].div0;
   assign div_ovf  = dm[PIPE_DEPTH-1].ovf;

   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   initial forever begin
      @(posedge clk); #1;
      if (rnd_on) rsp_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: pops on handshake, tracks outstanding credits and head stability.
   initial forever begin
      @(negedge clk);
      mon_cur = mk(rsp_q, rsp_s, rsp_div0, rsp_ovf, rsp_tag);
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk(1'b0, "rsp_unexpected", mon_cur, 0);
         else begin
            mon_exp = sb.pop_front();
            chk(mon_cur == mon_exp, "rsp", mon_cur, mon_exp);
         end
      end
      if (st_arm && rst_n && (!rsp_valid || mon_cur != st_prev)) stab_bad++;
      st_arm  = rst_n && rsp_valid && !rsp_ready;
      st_prev = mon_cur;
      if (!rst_n) out_cnt = 0;
      else begin
         if (int'(inflight) > out_cnt) led_bad++;
         out_cnt = out_cnt + int'(req_valid && req_ready) - int'(rsp_valid && rsp_ready);
         if (out_cnt > FD) led_bad++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   localparam logic [D_WIDTH:0] BP_Q [6] = '{9'd5, 9'd5, 9'd5, 9'd5, 9'd6, 9'd6};
   localparam logic [D_WIDTH:0] BP_S [6] = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd0, 9'd1};

   initial begin
      int k, hi, seen;
      logic [Z_WIDTH-1:0] rz;
      logic [D_WIDTH-1:0] rd;
      req_valid = 1'b0; req_z = '0; req_d = '0; req_tag = '0; rsp_ready = 1'b0;

      // Reset state and enable rising on the first edge after release.
      repeat (3) @(negedge clk);
      chk(outs() == 64'd0, "reset_outputs", outs(), 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk(div_ena == 1'b0, "ena_before_edge", div_ena, 0);
      @(negedge clk);
      chk({div_ena, req_ready} == 2'b11, "ena_ready_after_edge", {div_ena, req_ready}, 2'b11);
      step();

      // Single op and accept->rsp_valid latency.
      rsp_ready = 1'b1;
      issue(16'd100, 8'd7, 4'd3, mk(9'd14, 9'd2, 1'b0, 1'b0, 4'd3));
      k = 0;
      do begin @(negedge clk); k++; end while (!rsp_valid && k < 40);
      chk(cyc - acc_cyc == PIPE_DEPTH + 1, "latency", cyc - acc_cyc, PIPE_DEPTH + 1);
      step();
      wait_drain(20, "drain_single");

      // Signs, divide-by-zero and overflow, back to back.
      issue(16'hFF9C, 8'd7,   4'd5, mk(9'h1F2, 9'h1FE, 1'b0, 1'b0, 4'd5));
      issue(16'd50,   8'd0,   4'd6, mk(9'h1FF, 9'h000, 1'b1, 1'b0, 4'd6));
      issue(16'h0800, 8'd8,   4'd7, mk(9'h100, 9'h000, 1'b0, 1'b1, 4'd7));
      issue(16'h8000, 8'hFF,  4'd8, mk(9'h000, 9'h000, 1'b0, 1'b1, 4'd8));
      issue(16'hFF9C, 8'hF9,  4'd9, mk(9'h00E, 9'h1FE, 1'b0, 1'b0, 4'd9));
      wait_drain(40, "drain_signs");

      // Back-pressure: four credits, then blocked until the consumer pops.
      rsp_ready = 1'b0;
      for (int t = 0; t < 4; t++)
         issue(16'(20 + t), 8'd4, 4'(t), mk(BP_Q[t], BP_S[t], 1'b0, 1'b0, 4'(t)));
      req_z = 16'd24; req_d = 8'd4; req_tag = 4'd4; req_valid = 1'b1;
      hi = 0;
      repeat (20) begin @(negedge clk); if (req_ready) hi++; end
      chk(hi == 0, "credit_block", hi, 0);
      chk(out_cnt == 4, "outstanding_bp", out_cnt, 4);
      chk({rsp_valid, inflight} == {1'b1, 3'd0}, "bp_all_captured", {rsp_valid, inflight}, {1'b1, 3'd0});
      step();
      rsp_ready = 1'b1;
      issue(16'd24, 8'd4, 4'd4, mk(BP_Q[4], BP_S[4], 1'b0, 1'b0, 4'd4));
      issue(16'd25, 8'd4, 4'd5, mk(BP_Q[5], BP_S[5], 1'b0, 1'b0, 4'd5));
      wait_drain(60, "drain_bp");

      // Reset with work in flight: everything clears, stale results never surface.
      issue(16'd70, 8'd7, 4'd10, mk(9'd10, 9'd0, 1'b0, 1'b0, 4'd10));
      issue(16'd71, 8'd7, 4'd11, mk(9'd10, 9'd1, 1'b0, 1'b0, 4'd11));
      issue(16'd72, 8'd7, 4'd12, mk(9'd10, 9'd2, 1'b0, 1'b0, 4'd12));
      repeat (3) step();
      rst_n = 1'b0;
      @(negedge clk);
      chk(outs() == 64'd0, "reset_midop", outs(), 0);
      sb.delete();
      step();
      rst_n = 1'b1;
      seen = 0;
      repeat (2 * PIPE_DEPTH) begin @(negedge clk); if (rsp_valid) seen++; end
      chk(seen == 0, "no_stale_rsp", seen, 0);
      chk(inflight == '0, "inflight_after_reset", inflight, 0);
      step();
      issue(16'd100, 8'd7, 4'd13, mk(9'd14, 9'd2, 1'b0, 1'b0, 4'd13));
      wait_drain(30, "drain_after_reset");

      // Random stream with random consumer stalls.
      rnd_on = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) step();
         rz = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       rd = 8'd0;
            1:       rd = ($urandom_range(0, 1) == 1) ? 8'd1 : 8'hFF;
            default: rd = 8'($urandom);
         endcase
         issue(rz, rd, 4'(i), ref_div(rz, rd, 4'(i)));
      end
      rnd_on = 1'b0;
      rsp_ready = 1'b1;
      wait_drain(100, "drain_random");

      chk(led_bad == 0, "credit_ledger", led_bad, 0);
      chk(stab_bad == 0, "rsp_stable", stab_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
